// File: rtl/vote_recorder.sv
// vote_recorder: turns debounced candidate button levels into per-candidate
// vote tallies, one vote per press. Ambiguous presses (two or more buttons
// high) and presses on a saturated tally are rejected. After an accepted vote
// a fixed lockout runs, then the block waits until every button is released,
// so a held or bouncing button cannot vote twice.
//
// Ports:
//   clock              system clock, rising edge
//   reset              synchronous, active-high, clears all state
//   mode               0 = voting, 1 = result mode (presses ignored in IDLE)
//   candidateN_button  debounced button level, high while pressed (N = 1..4)
//   candidateN_vote    registered tally for candidate N
//   total_votes        registered sum of all accepted votes
//   valid_vote_casted  one-cycle pulse per accepted vote
//   invalid_vote       one-cycle pulse per rejected vote attempt
//   busy               high whenever the FSM is not IDLE
module vote_recorder #(
  parameter int unsigned LOCKOUT_CYCLES = 10,
  parameter int unsigned COUNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mode,
  input  logic               candidate1_button,
  input  logic               candidate2_button,
  input  logic               candidate3_button,
  input  logic               candidate4_button,
  output logic [COUNT_W-1:0] candidate1_vote,
  output logic [COUNT_W-1:0] candidate2_vote,
  output logic [COUNT_W-1:0] candidate3_vote,
  output logic [COUNT_W-1:0] candidate4_vote,
  output logic [COUNT_W+1:0] total_votes,
  output logic               valid_vote_casted,
  output logic               invalid_vote,
  output logic               busy
);

  localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOCKOUT,
    WAIT_RELEASE
  } state_t;

  state_t             state;
  logic [LW-1:0]      lock_cnt;
  logic [3:0]         buttons;
  logic [3:0]         btn_q;
  logic [3:0]         rise;
  logic               any_high;
  logic               one_high;
  logic [1:0]         sel;
  logic               sel_sat;
  logic [COUNT_W-1:0] tally [4];

  assign buttons  = {candidate4_button, candidate3_button,
                     candidate2_button, candidate1_button};
  assign rise     = buttons & ~btn_q;
  assign any_high = |buttons;

  // A rise with exactly one button high means that button is the sole
  // riser and nothing else is held: the only acceptable vote pattern.
  assign one_high = ($countones(buttons) == 1);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (rise[i]) sel = 2'(i);
    end
    sel_sat = (tally[sel] == '1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      lock_cnt          <= '0;
      btn_q             <= '0;
      total_votes       <= '0;
      valid_vote_casted <= 1'b0;
      invalid_vote      <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) tally[i] <= '0;
    end else begin
      btn_q             <= buttons;
      valid_vote_casted <= 1'b0;
      invalid_vote      <= 1'b0;
      case (state)
        IDLE: begin
          if (!mode && (rise != '0)) begin
            if (one_high && !sel_sat) begin
              tally[sel]        <= tally[sel] + COUNT_W'(1);
              total_votes       <= total_votes + (COUNT_W + 2)'(1);
              valid_vote_casted <= 1'b1;
              lock_cnt          <= LW'(LOCKOUT_CYCLES - 1);
              state             <= LOCKOUT;
            end else begin
              invalid_vote <= 1'b1;
              state        <= WAIT_RELEASE;
            end
          end
        end
        LOCKOUT: begin
          if (lock_cnt == '0) state <= WAIT_RELEASE;
          else                lock_cnt <= lock_cnt - LW'(1);
        end
        WAIT_RELEASE: begin
          if (!any_high) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign candidate1_vote = tally[0];
  assign candidate2_vote = tally[1];
  assign candidate3_vote = tally[2];
  assign candidate4_vote = tally[3];
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_vote_recorder.sv
// Bench for vote_recorder: a behavioural reference model predicts every
// cycle's outputs into a scoreboard queue; table rows and hand-written
// sequences additionally check end-of-segment tallies and pulse counts.
module tb_vote_recorder;

  localparam int unsigned LOCK = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       c1 = 1'b0, c2 = 1'b0, c3 = 1'b0, c4 = 1'b0;
  logic [7:0] v1, v2, v3, v4;
  logic [9:0] total;
  logic       valid_p, invalid_p, busy;

  vote_recorder #(.LOCKOUT_CYCLES(LOCK), .COUNT_W(8)) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .candidate1_button(c1), .candidate2_button(c2),
    .candidate3_button(c3), .candidate4_button(c4),
    .candidate1_vote(v1), .candidate2_vote(v2),
    .candidate3_vote(v3), .candidate4_vote(v4),
    .total_votes(total), .valid_vote_casted(valid_p),
    .invalid_vote(invalid_p), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int seen_v = 0;
  int seen_i = 0;

  // Reference model state: 0 idle, 1 lockout, 2 wait-for-release.
  int         m_t [4];
  int         m_st = 0;
  int         m_lock = 0;
  logic [3:0] m_prev = '0;
  logic [63:0] sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic m, input logic [3:0] b);
    logic [3:0] rise;
    int idx, sum;
    logic v, inv;
    v = 1'b0; inv = 1'b0;
    if (r) begin
      for (int i = 0; i < 4; i++) m_t[i] = 0;
      m_st = 0; m_lock = 0; m_prev = '0;
    end else begin
      rise = b & ~m_prev;
      idx = 0;
      for (int i = 0; i < 4; i++) if (rise[i]) idx = i;
      if (m_st == 0) begin
        if (!m && rise != 4'b0) begin
          if ($countones(b) == 1 && m_t[idx] < 255) begin
            m_t[idx]++; v = 1'b1; m_st = 1; m_lock = LOCK;
          end else begin
            inv = 1'b1; m_st = 2;
          end
        end
      end else if (m_st == 1) begin
        m_lock--;
        if (m_lock == 0) m_st = 2;
      end else begin
        if (b == 4'b0) m_st = 0;
      end
      m_prev = b;
    end
    sum = m_t[0] + m_t[1] + m_t[2] + m_t[3];
    sb_q.push_back(64'({8'(m_t[0]), 8'(m_t[1]), 8'(m_t[2]), 8'(m_t[3]),
                        10'(sum), v, inv, (m_st != 0)}));
  endtask

  task automatic cycle(input logic r, input logic m, input logic [3:0] b);
    logic [63:0] exp;
    reset = r; mode = m;
    {c4, c3, c2, c1} = b;
    model_step(r, m, b);
    @(posedge clock);
    @(negedge clock);
    exp = sb_q.pop_front();
    check("cycle", 64'({v1, v2, v3, v4, total, valid_p, invalid_p, busy}), exp);
    if (valid_p)   seen_v++;
    if (invalid_p) seen_i++;
  endtask

  typedef struct {
    logic       rst;
    logic       md;
    logic [3:0] btn;
    int         n;
    int         e1, e2, e3, e4;
    int         ev, ei;
    logic       ebusy;
  } vec_t;

  vec_t vecs [15];

  initial begin
    // rst md btn n | e1 e2 e3 e4 | ev ei busy  (btn = {c4,c3,c2,c1})
    vecs[0]  = '{1'b1, 1'b0, 4'b0000,  2, 0, 0, 0, 0, 0, 0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'b0010,  3, 0, 1, 0, 0, 1, 0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 4'b0000,  6, 0, 1, 0, 0, 0, 0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'b0001, 40, 1, 1, 0, 0, 1, 0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000,  3, 1, 1, 0, 0, 0, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'b0101,  4, 1, 1, 0, 0, 0, 1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 4'b0100,  2, 1, 1, 0, 0, 0, 0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 4'b0000,  2, 1, 1, 0, 0, 0, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'b1000,  3, 1, 1, 0, 0, 0, 0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'b0000,  2, 1, 1, 0, 0, 0, 0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'b1000,  1, 1, 1, 0, 1, 1, 0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 4'b0000,  6, 1, 1, 0, 1, 0, 0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'b0010,  2, 1, 1, 0, 1, 0, 0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 4'b0011,  1, 1, 1, 0, 1, 0, 1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 4'b0000,  2, 1, 1, 0, 1, 0, 0, 1'b0};

    for (int r = 0; r < 15; r++) begin
      seen_v = 0; seen_i = 0;
      for (int k = 0; k < vecs[r].n; k++) cycle(vecs[r].rst, vecs[r].md, vecs[r].btn);
      check($sformatf("row%0d_c1", r), 64'(v1), 64'(vecs[r].e1));
      check($sformatf("row%0d_c2", r), 64'(v2), 64'(vecs[r].e2));
      check($sformatf("row%0d_c3", r), 64'(v3), 64'(vecs[r].e3));
      check($sformatf("row%0d_c4", r), 64'(v4), 64'(vecs[r].e4));
      check($sformatf("row%0d_valid_cnt", r), 64'(seen_v), 64'(vecs[r].ev));
      check($sformatf("row%0d_invalid_cnt", r), 64'(seen_i), 64'(vecs[r].ei));
      check($sformatf("row%0d_busy", r), 64'(busy), 64'(vecs[r].ebusy));
    end

    // Saturation: 255 separated votes for candidate 3, then a 256th.
    cycle(1'b1, 1'b0, 4'b0000);
    seen_v = 0; seen_i = 0;
    for (int k = 0; k < 255; k++) begin
      cycle(1'b0, 1'b0, 4'b0100);
      for (int j = 0; j < LOCK + 3; j++) cycle(1'b0, 1'b0, 4'b0000);
    end
    check("sat_c3", 64'(v3), 64'd255);
    check("sat_total", 64'(total), 64'd255);
    check("sat_valid_cnt", 64'(seen_v), 64'd255);
    seen_v = 0; seen_i = 0;
    cycle(1'b0, 1'b0, 4'b0100);
    check("sat_invalid_pulse", 64'(invalid_p), 64'd1);
    check("sat_no_valid", 64'(valid_p), 64'd0);
    cycle(1'b0, 1'b0, 4'b0000);
    check("sat_c3_held", 64'(v3), 64'd255);
    check("sat_pulse_cnts", 64'({seen_v[7:0], seen_i[7:0]}), 64'h0001);

    // Reset in the middle of LOCKOUT after two votes.
    cycle(1'b1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 4'b0001);
    for (int j = 0; j < LOCK + 3; j++) cycle(1'b0, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 4'b0010);
    cycle(1'b0, 1'b0, 4'b0000);
    check("lock_busy", 64'(busy), 64'd1);
    check("lock_total", 64'(total), 64'd2);
    cycle(1'b1, 1'b0, 4'b0000);
    check("rst_tallies", 64'({v1, v2, v3, v4, total}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    cycle(1'b0, 1'b0, 4'b1000);
    check("post_rst_c4", 64'(v4), 64'd1);
    check("post_rst_total", 64'(total), 64'd1);
    check("post_rst_valid", 64'(valid_p), 64'd1);

    // A button held through reset reads as a fresh press afterwards.
    for (int j = 0; j < LOCK + 3; j++) cycle(1'b0, 1'b0, 4'b0000);
    cycle(1'b1, 1'b0, 4'b0010);
    cycle(1'b0, 1'b0, 4'b0010);
    check("held_rst_c2", 64'(v2), 64'd1);
    check("held_rst_valid", 64'(valid_p), 64'd1);
    for (int j = 0; j < LOCK + 3; j++) cycle(1'b0, 1'b0, 4'b0000);
    check("final_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
